lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Parametrised, handshaked load/store unit that replaces the fixed single-cycle LSU in the backend memory stage. Each accepted LB/LH/LW/LBU/LHU/SB/SH/SW issue packet gets an effective address. Stores are placed on the correct byte lanes and queued in an in-order store buffer. Loads run over a variable-latency request/grant/rvalid data-memory port, and the returned word is lane-extracted and sign- or zero-extended. Misaligned accesses are trapped and reported instead of being sent to memory.

## Interface
- LSU_ADDR_W, 32: effective address width.
- SB_DEPTH, 4: store-buffer entries; power of two, ≥2.
- i_clk  in  1  sole clock; all state changes on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  issue packet valid.
- o_ready  out  1  packet accepted when i_valid && o_ready.
- i_instr  in  operator_e  operation (LB..SW); any other value is a no-op.
- i_operand_a  in  LSU_ADDR_W  base (rs1).
- i_operand_b  in  LSU_ADDR_W  offset (imm).
- i_store_data  in  32  rs2 value for stores.
- i_rd_addr  in  5  load destination register.
- o_mem_req  out  1  memory request.
- i_mem_gnt  in  1  request accepted this cycle.
- o_mem_we  out  1  1 = store, 0 = load.
- o_mem_addr  out  LSU_ADDR_W  word address; bits [1:0] are forced to 0.
- o_mem_wdata  out  32  lane-aligned store data.
- o_mem_bytemask  out  4  byte enables.
- i_mem_rvalid  in  1  load data returned.
- i_mem_rdata  in  32  raw load word.
- o_wb_valid  out  1  load writeback pulse.
- o_wb_rd_addr  out  5  writeback destination.
- o_wb_data  out  32  extended load result.
- o_misalign  out  1  misalignment trap pulse.
- o_misalign_addr  out  LSU_ADDR_W  faulting effective address.

## Operation
- Address: ea = i_operand_a + i_operand_b, modulo 2^LSU_ADDR_W; carry out is discarded.
- Misalignment rules:
  - Half access is misaligned when ea[0]=1.
  - Word access is misaligned when ea[1:0]≠0.
  - A misaligned packet is consumed. The next cycle drives o_misalign=1 and o_misalign_addr=ea for one cycle.
  - The packet causes no memory access, no enqueue and no writeback.
- Store lanes, with o = ea[1:0]:
  - SB: mask = 4'b0001<<o; wdata = {4{data[7:0]}}.
  - SH: mask = 4'b0011<<o; wdata = {2{data[15:0]}}.
  - SW: mask = 4'b1111; wdata = data.
- Store buffer:
  - FIFO of {word addr, wdata, mask}, SB_DEPTH entries.
  - An accepted aligned store enqueues.
  - A pop occurs on a granted store request.
  - Enqueue and pop may coincide; count is then unchanged.
- o_ready, combinational, forced to 0 while i_rst_n=0:
  - Store: 1 when the buffer is not full. It stays 0 at full even if a pop occurs that same cycle.
  - Load: 1 only when FSM=IDLE, the buffer is empty, and no store request is being granted that cycle. All older stores must drain first.
  - Other ops and misaligned packets: 1.
- FSM states IDLE, ST_REQ, LD_REQ, LD_WAIT:
  - IDLE → LD_REQ on accepting an aligned load; ea, op and rd are captured.
  - IDLE → ST_REQ when the buffer is non-empty and no load is accepted.
  - ST_REQ: drive req=1, we=1, and the head entry's fields. On gnt, pop, then stay in ST_REQ if entries remain, else go to IDLE.
  - LD_REQ: drive req=1, we=0, word addr, and the lane mask of the load size. On gnt → LD_WAIT.
  - LD_WAIT: on i_mem_rvalid, extract the byte/half at the captured ea[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). Register the result to o_wb_*, then → IDLE.
- Request hold: o_mem_req and its fields hold stable until i_mem_gnt. The request is never withdrawn.
- rd=0: a load with rd=0 performs the memory read, but o_wb_valid stays 0.
- Reset, asserted any time including mid-transaction: FSM→IDLE, buffer emptied, captured load discarded.
  - Every output resets to 0 (o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bytemask, o_wb_valid, o_wb_rd_addr, o_wb_data, o_misalign, o_misalign_addr). o_ready is forced 0 combinationally as stated under o_ready.
  - A late rvalid after reset deassertion is ignored.

## Timing
- Store, empty buffer, IDLE: accept at cycle 0; o_mem_req high from cycle 1. Back-to-back granted stores issue one per cycle.
- Load, zero-wait memory:
  - Cycle 0: accept.
  - Cycle 1: req+gnt.
  - Cycle 2: rvalid.
  - Cycle 3: o_wb_valid.
- Load-to-use latency is therefore 3 cycles plus memory wait states.
- One load is outstanding at most. No new load is accepted until the cycle after writeback (IDLE).
- o_wb_valid and o_misalign are single-cycle registered pulses.

## Test plan
- SW a=0x8000_0000, b=4, data 0xDEAD_BEEF, gnt tied 1 → cycle 1: req, we=1, addr 0x8000_0004, mask 1111, wdata 0xDEAD_BEEF.
- SB ea=0x...03 data 0x0000_00A5 → mask 1000, wdata 0xA5A5_A5A5. SH ea=0x...02 → mask 1100.
- LB ea offset 1, rdata 0x0000_8000, rd=5 → o_wb_data 0xFFFF_FF80, rd 5. Same packet with LBU → 0x0000_0080. LH ea offset 2, rdata 0x8001_0000 → 0xFFFF_8001.
- LW ea offset 2 → o_misalign pulse with the address, no o_mem_req. LH ea offset 1 → likewise.
- Fill buffer with SB_DEPTH stores with gnt=0 → o_ready=0 for the next store. A load behind the stores waits until the last gnt, then issues.
- Assert i_rst_n=0 in LD_WAIT with 2 buffered stores → all outputs 0. After release, the rvalid is ignored and no writeback occurs.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: handshaked load/store unit with an in-order store buffer
// and a variable-latency req/gnt/rvalid data-memory port.
`timescale 1ns/1ps

package lsu_pkg;
  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd3,
    OP_LHU = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7,
    OP_NOP = 4'd15
  } operator_e;
endpackage

module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int LSU_ADDR_W = 32,
  parameter int SB_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  operator_e             i_instr,
  input  logic [LSU_ADDR_W-1:0] i_operand_a,
  input  logic [LSU_ADDR_W-1:0] i_operand_b,
  input  logic [31:0]           i_store_data,
  input  logic [4:0]            i_rd_addr,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic                  o_mem_we,
  output logic [LSU_ADDR_W-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_bytemask,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_wb_valid,
  output logic [4:0]            o_wb_rd_addr,
  output logic [31:0]           o_wb_data,
  output logic                  o_misalign,
  output logic [LSU_ADDR_W-1:0] o_misalign_addr
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_e;
  state_e state;

  // Size encoding: 0 = byte, 1 = half, 2 = word
  logic                  is_load, is_store, is_signed;
  logic [1:0]            size;
  logic [LSU_ADDR_W-1:0] ea, word_addr;
  logic                  misaligned;
  logic [3:0]            lane_mask;
  logic [31:0]           lane_wdata;
  logic                  accept, push, pop, ld_accept;

  // Store buffer storage and bookkeeping
  logic [LSU_ADDR_W-1:0] sb_addr  [SB_DEPTH];
  logic [31:0]           sb_wdata [SB_DEPTH];
  logic [3:0]            sb_mask  [SB_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]         count;
  logic                  sb_full, sb_empty;

  // Captured load context
  logic        ld_signed;
  logic [1:0]  ld_size, ld_off;
  logic [4:0]  ld_rd;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  assign ea         = i_operand_a + i_operand_b;
  assign word_addr  = {ea[LSU_ADDR_W-1:2], 2'b00};
  assign misaligned = ((size == 2'd1) && ea[0]) || ((size == 2'd2) && (ea[1:0] != 2'b00));
  assign sb_full    = (count == CW'(SB_DEPTH));
  assign sb_empty   = (count == '0);
  assign accept     = i_valid && o_ready;
  assign push       = accept && is_store && !misaligned;
  assign ld_accept  = accept && is_load && !misaligned;
  assign pop        = (state == ST_REQ) && i_mem_gnt;
  assign rd_ptr_nxt = rd_ptr + PW'(1);

  // Decode operation into load/store class, access size and signedness
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = 2'd0;
    case (i_instr)
      OP_LB:   begin is_load = 1'b1; is_signed = 1'b1; size = 2'd0; end
      OP_LH:   begin is_load = 1'b1; is_signed = 1'b1; size = 2'd1; end
      OP_LW:   begin is_load = 1'b1; size = 2'd2; end
      OP_LBU:  begin is_load = 1'b1; size = 2'd0; end
      OP_LHU:  begin is_load = 1'b1; size = 2'd1; end
      OP_SB:   begin is_store = 1'b1; size = 2'd0; end
      OP_SH:   begin is_store = 1'b1; size = 2'd1; end
      OP_SW:   begin is_store = 1'b1; size = 2'd2; end
      default: begin is_load = 1'b0; end
    endcase
  end

  // Byte-lane mask and replicated write data for the access size
  always_comb begin
    case (size)
      2'd0:    begin lane_mask = 4'b0001 << ea[1:0]; lane_wdata = {4{i_store_data[7:0]}}; end
      2'd1:    begin lane_mask = 4'b0011 << ea[1:0]; lane_wdata = {2{i_store_data[15:0]}}; end
      default: begin lane_mask = 4'b1111;            lane_wdata = i_store_data; end
    endcase
  end

  // Accept handshake: loads wait until all older stores have drained
  always_comb begin
    o_ready = 1'b0;
    if (i_rst_n) begin
      if (misaligned)    o_ready = 1'b1;
      else if (is_store) o_ready = !sb_full;
      else if (is_load)  o_ready = (state == IDLE) && sb_empty && !pop;
      else               o_ready = 1'b1;
    end
  end

  // Lane extraction and sign/zero extension of the returned load word
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = i_mem_rdata[7:0];
      2'd1:    ld_byte = i_mem_rdata[15:8];
      2'd2:    ld_byte = i_mem_rdata[23:16];
      default: ld_byte = i_mem_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (ld_size)
      2'd0:    ld_result = ld_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      2'd1:    ld_result = ld_signed ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default: ld_result = i_mem_rdata;
    endcase
  end

  // Store buffer payload write (no reset needed; validity tracked by count)
  always_ff @(posedge i_clk) begin
    if (push) begin
      sb_addr[wr_ptr]  <= word_addr;
      sb_wdata[wr_ptr] <= lane_wdata;
      sb_mask[wr_ptr]  <= lane_mask;
    end
  end

  // Store buffer pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Control FSM with registered memory-port, writeback and trap outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      o_mem_req       <= 1'b0;
      o_mem_we        <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_wdata     <= '0;
      o_mem_bytemask  <= '0;
      o_wb_valid      <= 1'b0;
      o_wb_rd_addr    <= '0;
      o_wb_data       <= '0;
      o_misalign      <= 1'b0;
      o_misalign_addr <= '0;
      ld_signed       <= 1'b0;
      ld_size         <= '0;
      ld_off          <= '0;
      ld_rd           <= '0;
    end else begin
      o_wb_valid <= 1'b0;
      o_misalign <= 1'b0;
      if (accept && misaligned) begin
        o_misalign      <= 1'b1;
        o_misalign_addr <= ea;
      end
      case (state)
        IDLE: begin
          if (ld_accept) begin
            state          <= LD_REQ;
            o_mem_req      <= 1'b1;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= word_addr;
            o_mem_wdata    <= '0;
            o_mem_bytemask <= lane_mask;
            ld_signed      <= is_signed;
            ld_size        <= size;
            ld_off         <= ea[1:0];
            ld_rd          <= i_rd_addr;
          end else if (!sb_empty) begin
            state          <= ST_REQ;
            o_mem_req      <= 1'b1;
            o_mem_we       <= 1'b1;
            o_mem_addr     <= sb_addr[rd_ptr];
            o_mem_wdata    <= sb_wdata[rd_ptr];
            o_mem_bytemask <= sb_mask[rd_ptr];
          end else if (push) begin
            // Empty buffer: present the incoming store directly next cycle
            state          <= ST_REQ;
            o_mem_req      <= 1'b1;
            o_mem_we       <= 1'b1;
            o_mem_addr     <= word_addr;
            o_mem_wdata    <= lane_wdata;
            o_mem_bytemask <= lane_mask;
          end
        end
        ST_REQ: begin
          if (i_mem_gnt) begin
            if (count > CW'(1)) begin
              o_mem_addr     <= sb_addr[rd_ptr_nxt];
              o_mem_wdata    <= sb_wdata[rd_ptr_nxt];
              o_mem_bytemask <= sb_mask[rd_ptr_nxt];
            end else if (push) begin
              o_mem_addr     <= word_addr;
              o_mem_wdata    <= lane_wdata;
              o_mem_bytemask <= lane_mask;
            end else begin
              state     <= IDLE;
              o_mem_req <= 1'b0;
              o_mem_we  <= 1'b0;
            end
          end
        end
        LD_REQ: begin
          if (i_mem_gnt) begin
            state     <= LD_WAIT;
            o_mem_req <= 1'b0;
          end
        end
        default: begin
          if (i_mem_rvalid) begin
            state        <= IDLE;
            o_wb_valid   <= (ld_rd != 5'd0);
            o_wb_rd_addr <= ld_rd;
            o_wb_data    <= ld_result;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed scenario tests for lsu_mem_ctrl.
`timescale 1ns/1ps

module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  operator_e   i_instr = OP_NOP;
  logic [31:0] i_operand_a = '0;
  logic [31:0] i_operand_b = '0;
  logic [31:0] i_store_data = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        o_mem_req;
  logic        i_mem_gnt = 1'b0;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bytemask;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd_addr;
  logic [31:0] o_wb_data;
  logic        o_misalign;
  logic [31:0] o_misalign_addr;

  int total = 0;
  int bad = 0;

  lsu_mem_ctrl #(.LSU_ADDR_W(32), .SB_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_store_data(i_store_data), .i_rd_addr(i_rd_addr),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bytemask(o_mem_bytemask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_rd_addr(o_wb_rd_addr), .o_wb_data(o_wb_data),
    .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input operator_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic [4:0] rd);
    i_valid      = 1'b1;
    i_instr      = op;
    i_operand_a  = a;
    i_operand_b  = b;
    i_store_data = d;
    i_rd_addr    = rd;
  endtask

  task automatic idle_in();
    i_valid = 1'b0;
    i_instr = OP_NOP;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive(OP_SW, 32'h10, 32'h0, 32'h1, 5'd1);
    tick();
    tick();
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    total++;
    if ({o_mem_req, o_mem_we, o_mem_bytemask, o_mem_addr, o_mem_wdata} !== 70'd0) begin
      bad++; $display("FAIL reset_mem got req=%b addr=%h exp all 0", o_mem_req, o_mem_addr);
    end
    total++;
    if ({o_wb_valid, o_wb_rd_addr, o_wb_data, o_misalign, o_misalign_addr} !== 71'd0) begin
      bad++; $display("FAIL reset_wb got wbv=%b wbd=%h mis=%b exp all 0", o_wb_valid, o_wb_data, o_misalign);
    end
    idle_in();
    i_rst_n = 1'b1;
    tick();
    $display("txn reset released");
  endtask

  task automatic test_store_word();
    i_mem_gnt = 1'b1;
    drive(OP_SW, 32'h8000_0000, 32'h4, 32'hDEAD_BEEF, 5'd0);
    #1;
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b exp=1", o_ready); end
    tick();
    idle_in();
    total++;
    if ({o_mem_req, o_mem_we, o_mem_bytemask} !== 6'b11_1111) begin
      bad++; $display("FAIL sw_ctrl got=%b exp=111111", {o_mem_req, o_mem_we, o_mem_bytemask});
    end
    total++;
    if (o_mem_addr !== 32'h8000_0004) begin bad++; $display("FAIL sw_addr got=%h exp=80000004", o_mem_addr); end
    total++;
    if (o_mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_mem_wdata); end
    tick();
    total++;
    if (o_mem_req !== 1'b0) begin bad++; $display("FAIL sw_done got=%b exp=0", o_mem_req); end
    $display("txn SW addr=80000004 data=deadbeef");
  endtask

  task automatic test_back_to_back();
    i_mem_gnt = 1'b1;
    drive(OP_SB, 32'h100, 32'h3, 32'h0000_00A5, 5'd0);
    tick();
    drive(OP_SH, 32'h200, 32'h2, 32'h0000_1234, 5'd0);
    #1;
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", o_ready); end
    total++;
    if ({o_mem_req, o_mem_we, o_mem_bytemask, o_mem_addr, o_mem_wdata} !== {2'b11, 4'b1000, 32'h100, 32'hA5A5_A5A5}) begin
      bad++; $display("FAIL sb_lanes got mask=%b addr=%h wdata=%h exp mask=1000 addr=100 wdata=a5a5a5a5",
                      o_mem_bytemask, o_mem_addr, o_mem_wdata);
    end
    $display("txn SB ea=103 data=a5");
    tick();
    idle_in();
    total++;
    if ({o_mem_req, o_mem_we, o_mem_bytemask, o_mem_addr, o_mem_wdata} !== {2'b11, 4'b1100, 32'h200, 32'h1234_1234}) begin
      bad++; $display("FAIL sh_lanes got mask=%b addr=%h wdata=%h exp mask=1100 addr=200 wdata=12341234",
                      o_mem_bytemask, o_mem_addr, o_mem_wdata);
    end
    $display("txn SH ea=202 data=1234");
    tick();
    total++;
    if (o_mem_req !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b exp=0", o_mem_req); end
  endtask

  task automatic test_load_extend();
    operator_e   ops   [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    logic [31:0] offs  [5] = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd0};
    logic [31:0] rdata [5] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000, 32'h8001_0000, 32'hCAFE_F00D};
    logic [31:0] expv  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hCAFE_F00D};
    logic [3:0]  masks [5] = '{4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1111};
    i_mem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 32'h1000, offs[i], 32'h0, 5'd5);
      #1;
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL ld%0d_ready got=%b exp=1", i, o_ready); end
      tick();
      idle_in();
      total++;
      if ({o_mem_req, o_mem_we, o_mem_bytemask, o_mem_addr} !== {2'b10, masks[i], 32'h1000}) begin
        bad++; $display("FAIL ld%0d_req got req=%b we=%b mask=%b addr=%h exp req=1 we=0 mask=%b addr=1000",
                        i, o_mem_req, o_mem_we, o_mem_bytemask, o_mem_addr, masks[i]);
      end
      tick();
      total++;
      if (o_mem_req !== 1'b0) begin bad++; $display("FAIL ld%0d_wait got req=%b exp=0", i, o_mem_req); end
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rdata[i];
      tick();
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      total++;
      if ({o_wb_valid, o_wb_rd_addr, o_wb_data} !== {1'b1, 5'd5, expv[i]}) begin
        bad++; $display("FAIL ld%0d_wb got v=%b rd=%0d data=%h exp v=1 rd=5 data=%h",
                        i, o_wb_valid, o_wb_rd_addr, o_wb_data, expv[i]);
      end
      tick();
      total++;
      if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL ld%0d_pulse got=%b exp=0", i, o_wb_valid); end
      $display("txn load %0d rdata=%h result=%h", i, rdata[i], o_wb_data);
    end
  endtask

  task automatic test_rd_zero();
    i_mem_gnt = 1'b1;
    drive(OP_LW, 32'h1000, 32'h4, 32'h0, 5'd0);
    tick();
    idle_in();
    total++;
    if ({o_mem_req, o_mem_we, o_mem_addr} !== {2'b10, 32'h1004}) begin
      bad++; $display("FAIL rd0_req got req=%b addr=%h exp req=1 addr=1004", o_mem_req, o_mem_addr);
    end
    tick();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h1234_5678;
    tick();
    i_mem_rvalid = 1'b0;
    total++;
    if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL rd0_wb got=%b exp=0", o_wb_valid); end
    tick();
    $display("txn LW rd=0 no writeback");
  endtask

  task automatic test_misalign();
    operator_e   ops  [3] = '{OP_LW, OP_LH, OP_SW};
    logic [31:0] offs [3] = '{32'd2, 32'd1, 32'd3};
    i_mem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 32'h2000, offs[i], 32'hFFFF_FFFF, 5'd3);
      #1;
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL mis%0d_ready got=%b exp=1", i, o_ready); end
      tick();
      idle_in();
      total++;
      if ({o_misalign, o_misalign_addr, o_mem_req} !== {1'b1, 32'h2000 + offs[i], 1'b0}) begin
        bad++; $display("FAIL mis%0d_trap got mis=%b addr=%h req=%b exp mis=1 addr=%h req=0",
                        i, o_misalign, o_misalign_addr, o_mem_req, 32'h2000 + offs[i]);
      end
      tick();
      total++;
      if ({o_misalign, o_mem_req, o_wb_valid} !== 3'b000) begin
        bad++; $display("FAIL mis%0d_after got mis=%b req=%b wbv=%b exp 000", i, o_misalign, o_mem_req, o_wb_valid);
      end
      $display("txn misaligned op %0d ea=%h", i, 32'h2000 + offs[i]);
    end
  endtask

  task automatic test_buffer_full();
    i_mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_SW, 32'h3000, 32'(4 * i), 32'h100 + 32'(i), 5'd0);
      #1;
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL fill%0d_ready got=%b exp=1", i, o_ready); end
      tick();
    end
    drive(OP_SW, 32'h3010, 32'h0, 32'h999, 5'd0);
    #1;
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL full_st_ready got=%b exp=0", o_ready); end
    drive(OP_LW, 32'h4000, 32'h0, 32'h0, 5'd7);
    #1;
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL full_ld_ready got=%b exp=0", o_ready); end
    tick();
    tick();
    total++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== {2'b11, 32'h3000, 32'h100}) begin
      bad++; $display("FAIL hold got req=%b addr=%h wdata=%h exp req=1 addr=3000 wdata=100",
                      o_mem_req, o_mem_addr, o_mem_wdata);
    end
    i_mem_gnt = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j == 0) begin
        i_instr = OP_SW;
        #1;
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL full_pop_st_ready got=%b exp=0", o_ready); end
        i_instr = OP_LW;
        #1;
      end
      total++;
      if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_ready} !== {2'b11, 32'h3000 + 32'(4 * j), 32'h100 + 32'(j), 1'b0}) begin
        bad++; $display("FAIL drain%0d got req=%b addr=%h wdata=%h rdy=%b exp addr=%h wdata=%h rdy=0",
                        j, o_mem_req, o_mem_addr, o_mem_wdata, o_ready, 32'h3000 + 32'(4 * j), 32'h100 + 32'(j));
      end
      tick();
    end
    total++;
    if ({o_mem_req, o_ready} !== 2'b01) begin
      bad++; $display("FAIL drained got req=%b rdy=%b exp req=0 rdy=1", o_mem_req, o_ready);
    end
    tick();
    idle_in();
    total++;
    if ({o_mem_req, o_mem_we, o_mem_bytemask, o_mem_addr} !== {2'b10, 4'b1111, 32'h4000}) begin
      bad++; $display("FAIL late_ld_req got req=%b we=%b addr=%h exp req=1 we=0 addr=4000", o_mem_req, o_mem_we, o_mem_addr);
    end
    tick();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h1122_3344;
    tick();
    i_mem_rvalid = 1'b0;
    total++;
    if ({o_wb_valid, o_wb_rd_addr, o_wb_data} !== {1'b1, 5'd7, 32'h1122_3344}) begin
      bad++; $display("FAIL late_ld_wb got v=%b rd=%0d data=%h exp v=1 rd=7 data=11223344",
                      o_wb_valid, o_wb_rd_addr, o_wb_data);
    end
    tick();
    $display("txn 4 stores drained then LW rd=7");
  endtask

  task automatic test_reset_mid();
    i_mem_gnt = 1'b1;
    drive(OP_LW, 32'h5000, 32'h0, 32'h0, 5'd9);
    tick();
    idle_in();
    tick();
    drive(OP_SW, 32'h6000, 32'h0, 32'h1, 5'd0);
    tick();
    drive(OP_SW, 32'h6004, 32'h0, 32'h2, 5'd0);
    tick();
    idle_in();
    total++;
    if (o_mem_req !== 1'b0) begin bad++; $display("FAIL ldwait_req got=%b exp=0", o_mem_req); end
    #2;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", o_ready); end
    total++;
    if ({o_mem_req, o_mem_we, o_mem_bytemask, o_mem_addr, o_mem_wdata} !== 70'd0) begin
      bad++; $display("FAIL mid_rst_mem got req=%b addr=%h wdata=%h exp all 0", o_mem_req, o_mem_addr, o_mem_wdata);
    end
    total++;
    if ({o_wb_valid, o_wb_rd_addr, o_wb_data, o_misalign, o_misalign_addr} !== 71'd0) begin
      bad++; $display("FAIL mid_rst_wb got wbd=%h misaddr=%h exp all 0", o_wb_data, o_misalign_addr);
    end
    tick();
    i_rst_n = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hFFFF_FFFF;
    tick();
    i_mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o_wb_valid, o_mem_req} !== 2'b00) begin
        bad++; $display("FAIL post_rst%0d got wbv=%b req=%b exp 00", k, o_wb_valid, o_mem_req);
      end
      tick();
    end
    $display("txn reset during LD_WAIT with 2 buffered stores");
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_back_to_back();
    test_load_extend();
    test_rd_zero();
    test_misalign();
    test_buffer_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
